// File: rtl/imem_port_arbiter_if.sv
// Bundle between the IF stage, the program loader, the byte-wide instruction memory and imem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface imem_port_arbiter_if #(
   parameter int DATA_W    = 32,
   parameter int BYTE_W    = 8,
   parameter int MEM_DEPTH = 256
);
   localparam int AW = $clog2(MEM_DEPTH);

   logic              fetch_req;
   logic [DATA_W-1:0] fetch_addr;
   logic              fetch_flush;
   logic              fetch_gnt;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_instr;

   logic              load_req;
   logic [DATA_W-1:0] load_addr;
   logic [DATA_W-1:0] load_data;
   logic              load_gnt;
   logic              load_done;

   logic              busy;

   logic              mem_en;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [BYTE_W-1:0] mem_wdata;
   logic [BYTE_W-1:0] mem_rdata;

   modport slave (
      input  fetch_req, fetch_addr, fetch_flush,
      input  load_req, load_addr, load_data,
      input  mem_rdata,
      output fetch_gnt, fetch_valid, fetch_instr,
      output load_gnt, load_done, busy,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output fetch_req, fetch_addr, fetch_flush,
      output load_req, load_addr, load_data,
      output mem_rdata,
      input  fetch_gnt, fetch_valid, fetch_instr,
      input  load_gnt, load_done, busy,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares a byte-wide instruction memory between the IF fetch port and the program loader (big-endian words).
// Optional macro IMEM_ARB_RR_EN: round-robin fetch/load priority instead of fixed load-first.
//
// state  | meaning
// IDLE   | no transfer; grants may be issued
// F_RD   | issuing fetch read beats 0..NB-1
// F_LAST | capturing the final read byte
// F_DONE | fetch_valid pulse with the new instruction
// L_WR   | issuing loader write beats 0..NB-1
// L_DONE | load_done pulse
module imem_port_arbiter #(
   parameter int DATA_W    = 32,
   parameter int BYTE_W    = 8,
   parameter int MEM_DEPTH = 256
) (
   input logic                clk,
   input logic                rst,
   imem_port_arbiter_if.slave bus
);
   localparam int NB = DATA_W / BYTE_W;
   localparam int AW = $clog2(MEM_DEPTH);
   localparam int BW = $clog2(NB);
   localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

   typedef enum logic [2:0] {IDLE, F_RD, F_LAST, F_DONE, L_WR, L_DONE} state_t;

   state_t            state;
   logic [BW-1:0]     beat;
   logic [AW-1:0]     base;
   logic [DATA_W-1:0] word_q;
   logic              idle;
   logic              fetch_cand;
   logic              load_pri;
   logic [AW-1:0]     fetch_base;
   logic [AW-1:0]     load_base;
   logic [AW-1:0]     next_addr;
   logic              unused_addr_bits;

   assign fetch_base = {bus.fetch_addr[AW-1:BW], {BW{1'b0}}};
   assign load_base  = {bus.load_addr[AW-1:BW], {BW{1'b0}}};
   assign next_addr  = base + {{(AW-BW){1'b0}}, beat} + AW'(1);
   assign unused_addr_bits = ^{bus.fetch_addr[DATA_W-1:AW], bus.fetch_addr[BW-1:0],
                               bus.load_addr[DATA_W-1:AW], bus.load_addr[BW-1:0]};

   assign idle       = (state == IDLE) && !rst;
   assign fetch_cand = bus.fetch_req && !bus.fetch_flush;

`ifdef IMEM_ARB_RR_EN
   logic rr_load_pri;

   // Whoever was granted last yields on the next simultaneous request.
   always_ff @(posedge clk) begin
      if (rst)
         rr_load_pri <= 1'b0;
      else if (bus.load_gnt)
         rr_load_pri <= 1'b0;
      else if (bus.fetch_gnt)
         rr_load_pri <= 1'b1;
   end

   assign load_pri = rr_load_pri;
`else
   assign load_pri = 1'b1;
`endif

   assign bus.load_gnt  = idle && bus.load_req && (load_pri || !fetch_cand);
   assign bus.fetch_gnt = idle && fetch_cand && !bus.load_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         beat            <= '0;
         base            <= '0;
         word_q          <= '0;
         bus.fetch_instr <= '0;
         bus.fetch_valid <= 1'b0;
         bus.load_done   <= 1'b0;
         bus.busy        <= 1'b0;
         bus.mem_en      <= 1'b0;
         bus.mem_we      <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.load_gnt) begin
                  state         <= L_WR;
                  base          <= load_base;
                  beat          <= '0;
                  word_q        <= bus.load_data;
                  bus.busy      <= 1'b1;
                  bus.mem_en    <= 1'b1;
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= load_base;
                  bus.mem_wdata <= bus.load_data[DATA_W-1 -: BYTE_W];
               end else if (bus.fetch_gnt) begin
                  state        <= F_RD;
                  base         <= fetch_base;
                  beat         <= '0;
                  bus.busy     <= 1'b1;
                  bus.mem_en   <= 1'b1;
                  bus.mem_we   <= 1'b0;
                  bus.mem_addr <= fetch_base;
               end
            end
            F_RD: begin
               // Read data lags the address by one cycle, so beat k captures byte k-1.
               if (beat != '0)
                  word_q <= {word_q[DATA_W-BYTE_W-1:0], bus.mem_rdata};
               if (bus.fetch_flush) begin
                  state      <= IDLE;
                  beat       <= '0;
                  bus.busy   <= 1'b0;
                  bus.mem_en <= 1'b0;
               end else if (beat == LAST_BEAT) begin
                  state      <= F_LAST;
                  beat       <= '0;
                  bus.mem_en <= 1'b0;
               end else begin
                  beat         <= beat + BW'(1);
                  bus.mem_addr <= next_addr;
               end
            end
            F_LAST: begin
               if (bus.fetch_flush) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  state           <= F_DONE;
                  bus.fetch_instr <= {word_q[DATA_W-BYTE_W-1:0], bus.mem_rdata};
                  bus.fetch_valid <= 1'b1;
               end
            end
            F_DONE: begin
               state           <= IDLE;
               bus.fetch_valid <= 1'b0;
               bus.busy        <= 1'b0;
            end
            L_WR: begin
               if (beat == LAST_BEAT) begin
                  state         <= L_DONE;
                  beat          <= '0;
                  bus.mem_en    <= 1'b0;
                  bus.mem_we    <= 1'b0;
                  bus.load_done <= 1'b1;
               end else begin
                  beat          <= beat + BW'(1);
                  bus.mem_addr  <= next_addr;
                  word_q        <= word_q << BYTE_W;
                  bus.mem_wdata <= word_q[DATA_W-BYTE_W-1 -: BYTE_W];
               end
            end
            L_DONE: begin
               state         <= IDLE;
               bus.load_done <= 1'b0;
               bus.busy      <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: vector table of fetch/load transactions plus flush, arbitration and reset sequences.
// Expectations follow IMEM_ARB_RR_EN when it is defined for the build.
module tb_imem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_port_arbiter_if bus ();

   imem_port_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef IMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // Byte-wide synchronous memory with a preload port for setup.
   logic [7:0] tbmem [256];
   logic [7:0] rdata_q = 8'h00;
   logic       pl_we = 1'b0;
   logic [7:0] pl_addr = 8'h00;
   logic [7:0] pl_data = 8'h00;

   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we)
         tbmem[bus.mem_addr] <= bus.mem_wdata;
      else if (pl_we)
         tbmem[pl_addr] <= pl_data;
      if (bus.mem_en && !bus.mem_we)
         rdata_q <= tbmem[bus.mem_addr];
   end
   assign bus.mem_rdata = rdata_q;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      pl_addr = a;
      pl_data = d;
      pl_we   = 1'b1;
      @(negedge clk);
      pl_we   = 1'b0;
   endtask

   task automatic run_fetch(input logic [31:0] a, input logic [7:0] base, input logic [31:0] exp);
      logic [7:0] ea;
      @(negedge clk);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = a;
      #1;
      chk1("fetch_gnt", bus.fetch_gnt, 1'b1);
      chk1("fetch_idle_busy", bus.busy, 1'b0);
      @(negedge clk);
      bus.fetch_req = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         ea = base + 8'(k);
         chk1("fetch_mem_en", bus.mem_en, 1'b1);
         chk1("fetch_mem_we", bus.mem_we, 1'b0);
         chk8("fetch_mem_addr", bus.mem_addr, ea);
         chk1("fetch_valid_early", bus.fetch_valid, 1'b0);
         @(negedge clk);
         #1;
      end
      chk1("fetch_last_mem_en", bus.mem_en, 1'b0);
      chk1("fetch_last_valid", bus.fetch_valid, 1'b0);
      @(negedge clk);
      #1;
      chk1("fetch_valid", bus.fetch_valid, 1'b1);
      chk32("fetch_instr", bus.fetch_instr, exp);
      @(negedge clk);
      #1;
      chk1("fetch_valid_end", bus.fetch_valid, 1'b0);
      chk1("fetch_busy_end", bus.busy, 1'b0);
   endtask

   task automatic run_load(input logic [31:0] a, input logic [31:0] d, input logic [7:0] base);
      logic [7:0] ea;
      logic [7:0] eb;
      @(negedge clk);
      bus.load_req  = 1'b1;
      bus.load_addr = a;
      bus.load_data = d;
      #1;
      chk1("load_gnt", bus.load_gnt, 1'b1);
      @(negedge clk);
      bus.load_req = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         ea = base + 8'(k);
         eb = d[31-8*k -: 8];
         chk1("load_mem_en", bus.mem_en, 1'b1);
         chk1("load_mem_we", bus.mem_we, 1'b1);
         chk8("load_mem_addr", bus.mem_addr, ea);
         chk8("load_mem_wdata", bus.mem_wdata, eb);
         chk1("load_done_early", bus.load_done, 1'b0);
         @(negedge clk);
         #1;
      end
      chk1("load_done", bus.load_done, 1'b1);
      chk1("load_done_mem_en", bus.mem_en, 1'b0);
      @(negedge clk);
      #1;
      chk1("load_done_end", bus.load_done, 1'b0);
      chk1("load_busy_end", bus.busy, 1'b0);
      for (int k = 0; k < 4; k++) begin
         ea = base + 8'(k);
         eb = d[31-8*k -: 8];
         chk8("load_mem_byte", tbmem[ea], eb);
      end
   endtask

   task automatic sim_both(input logic [31:0] la, input logic [31:0] ld,
                           input logic [31:0] fa, input logic [31:0] fexp);
      int fg, fv, lg, ldn;
      if (RR) begin fg = 0; fv = 6;  lg = 7; ldn = 12; end
      else    begin lg = 0; ldn = 5; fg = 6; fv = 12;  end
      @(negedge clk);
      bus.load_req   = 1'b1;
      bus.load_addr  = la;
      bus.load_data  = ld;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = fa;
      for (int c = 0; c < 14; c++) begin
         #1;
         chk1("both_fetch_gnt", bus.fetch_gnt, c == fg);
         chk1("both_load_gnt", bus.load_gnt, c == lg);
         chk1("both_fetch_valid", bus.fetch_valid, c == fv);
         chk1("both_load_done", bus.load_done, c == ldn);
         if (c == fv) chk32("both_fetch_instr", bus.fetch_instr, fexp);
         @(posedge clk);
         #1;
         if (c == fg) bus.fetch_req = 1'b0;
         if (c == lg) bus.load_req = 1'b0;
         @(negedge clk);
      end
   endtask

   typedef struct {
      bit          is_load;
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  base;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{0, 32'h0000_0000, 32'h0,           8'h00, 32'h8020_000A};
      vecs[1] = '{1, 32'h0000_0040, 32'hDEAD_BEEF,   8'h40, 32'h0};
      vecs[2] = '{0, 32'h0000_0040, 32'h0,           8'h40, 32'hDEAD_BEEF};
      vecs[3] = '{0, 32'h0000_0102, 32'h0,           8'h00, 32'h8020_000A};
      vecs[4] = '{0, 32'h0000_00FC, 32'h0,           8'hFC, 32'h1122_3344};
      vecs[5] = '{1, 32'h0000_0083, 32'hCAFE_F00D,   8'h80, 32'h0};
      vecs[6] = '{0, 32'hFFFF_FF81, 32'h0,           8'h80, 32'hCAFE_F00D};

      bus.fetch_req   = 1'b1;
      bus.fetch_addr  = '0;
      bus.fetch_flush = 1'b0;
      bus.load_req    = 1'b0;
      bus.load_addr   = '0;
      bus.load_data   = '0;

      poke(8'h00, 8'h80); poke(8'h01, 8'h20); poke(8'h02, 8'h00); poke(8'h03, 8'h0A);
      poke(8'h10, 8'hAA); poke(8'h11, 8'hBB); poke(8'h12, 8'hCC); poke(8'h13, 8'hDD);
      poke(8'h14, 8'h12); poke(8'h15, 8'h34); poke(8'h16, 8'h56); poke(8'h17, 8'h78);
      poke(8'hFC, 8'h11); poke(8'hFD, 8'h22); poke(8'hFE, 8'h33); poke(8'hFF, 8'h44);
      poke(8'h60, 8'h00); poke(8'h61, 8'h00); poke(8'h62, 8'h00); poke(8'h63, 8'h00);

      // Reset state, with a fetch request pending that must not be granted.
      #1;
      chk1("rst_fetch_gnt", bus.fetch_gnt, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_mem_en", bus.mem_en, 1'b0);
      chk1("rst_fetch_valid", bus.fetch_valid, 1'b0);
      chk32("rst_fetch_instr", bus.fetch_instr, 32'h0);
      bus.fetch_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].is_load) run_load(vecs[i].addr, vecs[i].data, vecs[i].base);
         else run_fetch(vecs[i].addr, vecs[i].base, vecs[i].exp);
      end

      // Flush in the grant cycle suppresses the fetch grant.
      @(negedge clk);
      bus.fetch_req   = 1'b1;
      bus.fetch_flush = 1'b1;
      #1;
      chk1("flush_gnt_suppress", bus.fetch_gnt, 1'b0);
      @(negedge clk);
      #1;
      chk1("flush_no_accept", bus.busy, 1'b0);
      bus.fetch_req   = 1'b0;
      bus.fetch_flush = 1'b0;

      // Simultaneous requests right after a load.
      run_load(32'h20, 32'h0102_0304, 8'h20);
      sim_both(32'h24, 32'h0506_0708, 32'h0, 32'h8020_000A);
      chk8("both_load_byte0", tbmem[8'h24], 8'h05);
      chk8("both_load_byte3", tbmem[8'h27], 8'h08);

      // Flush in cycle 3 of a fetch, then an immediate fetch of 0x14.
      @(negedge clk);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h10;
      #1;
      chk1("fl_gnt", bus.fetch_gnt, 1'b1);
      @(negedge clk);
      bus.fetch_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.fetch_flush = 1'b1;
      #1;
      chk1("fl_c3_mem_en", bus.mem_en, 1'b1);
      chk8("fl_c3_mem_addr", bus.mem_addr, 8'h12);
      @(negedge clk);
      bus.fetch_flush = 1'b0;
      bus.fetch_req   = 1'b1;
      bus.fetch_addr  = 32'h14;
      #1;
      chk1("fl_c4_mem_en", bus.mem_en, 1'b0);
      chk1("fl_c4_busy", bus.busy, 1'b0);
      chk1("fl_c4_valid", bus.fetch_valid, 1'b0);
      chk32("fl_c4_instr", bus.fetch_instr, 32'h8020_000A);
      chk1("fl_refetch_gnt", bus.fetch_gnt, 1'b1);
      @(negedge clk);
      bus.fetch_req = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk8("fl_refetch_addr", bus.mem_addr, 8'h14 + 8'(k));
         chk1("fl_refetch_valid", bus.fetch_valid, 1'b0);
         chk32("fl_instr_hold", bus.fetch_instr, 32'h8020_000A);
         @(negedge clk);
         #1;
      end
      chk1("fl_last_valid", bus.fetch_valid, 1'b0);
      @(negedge clk);
      #1;
      chk1("fl_refetch_valid", bus.fetch_valid, 1'b1);
      chk32("fl_refetch_instr", bus.fetch_instr, 32'h1234_5678);
      @(negedge clk);

      // Reset during cycle 2 of a load.
      @(negedge clk);
      bus.load_req  = 1'b1;
      bus.load_addr = 32'h60;
      bus.load_data = 32'h1122_3344;
      #1;
      chk1("rl_gnt", bus.load_gnt, 1'b1);
      @(negedge clk);
      bus.load_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk8("rl_c2_addr", bus.mem_addr, 8'h61);
      @(negedge clk);
      #1;
      chk1("rl_mem_en", bus.mem_en, 1'b0);
      chk1("rl_mem_we", bus.mem_we, 1'b0);
      chk1("rl_busy", bus.busy, 1'b0);
      chk1("rl_load_done", bus.load_done, 1'b0);
      chk32("rl_fetch_instr", bus.fetch_instr, 32'h0);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         chk1("rl_no_done", bus.load_done, 1'b0);
         chk1("rl_idle_mem_en", bus.mem_en, 1'b0);
      end
      chk8("rl_byte0", tbmem[8'h60], 8'h11);
      chk8("rl_byte2", tbmem[8'h62], 8'h00);
      chk8("rl_byte3", tbmem[8'h63], 8'h00);

      // After reset the priority is back to its starting point.
      sim_both(32'h30, 32'hA1B2_C3D4, 32'h14, 32'h1234_5678);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-ported, byte-wide instruction memory between two requesters: the IF-stage fetch port and a program-loader port used for boot and debug writes.
- Assembles each 32-bit big-endian instruction word from byte beats and writes loader words as big-endian byte beats.
- Sits between the IF stage / loader and the instruction memory array.
- Supports flush of an in-flight fetch on a taken branch or jump.

Parameters:
- DATA_W, `WORD_LEN (32): instruction/word width.
- BYTE_W, `MEM_CELL_SIZE (8): memory cell width; NB = DATA_W/BYTE_W beats per word (4).
- MEM_DEPTH, `INSTR_MEM_SIZE (256): memory depth in bytes; AW = $clog2(MEM_DEPTH).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request; held until fetch_gnt.
- fetch_addr  in  DATA_W  fetch byte address.
- fetch_flush  in  1  abort fetch (branch/jump taken).
- fetch_gnt  out  1  combinational accept pulse.
- fetch_valid  out  1  one-cycle pulse: fetch_instr valid.
- fetch_instr  out  DATA_W  assembled instruction; holds until next completion.
- load_req  in  1  loader write request; held until load_gnt.
- load_addr  in  DATA_W  loader byte address.
- load_data  in  DATA_W  word to write.
- load_gnt  out  1  combinational accept pulse.
- load_done  out  1  one-cycle pulse: write complete.
- busy  out  1  state != IDLE.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory byte address.
- mem_wdata  out  BYTE_W  write byte.
- mem_rdata  in  BYTE_W  read byte; valid the cycle after mem_en with mem_we=0.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset (including mid-operation): state IDLE; every output is 0, including fetch_instr; the beat counter and RR pointer clear; no partial completion pulse is issued.
- States: IDLE, F_RD, F_LAST, F_DONE, L_WR, L_DONE.
- Address handling: base = addr[AW-1:0] with bits [1:0] forced to 0. Beat k uses address (base+k) mod MEM_DEPTH. Address and data are latched at accept.
- Grant: only in IDLE, combinational. Fixed priority: load wins over fetch. fetch_gnt is suppressed when fetch_flush=1 in the same cycle.
- Fetch timing (accept at edge 0):
  - Cycles 1..4 are F_RD: mem_en=1, mem_we=0, mem_addr=base+k.
  - The byte read in cycle k is captured at the end of cycle k+1. Byte 0 goes to fetch_instr[31:24] (big-endian).
  - Cycle 5 is F_LAST.
  - Cycle 6 is F_DONE: fetch_valid=1 with the new fetch_instr.
  - Cycle 7 is IDLE. Minimum fetch period is 7 cycles.
- Flush: fetch_flush=1 in F_RD, F_LAST or F_DONE moves to IDLE at the next edge. mem_en=0 from that edge, fetch_valid stays 0, and fetch_instr keeps its previous value. Flush is ignored in L_* states.
- Load timing (accept at edge 0):
  - Cycles 1..4 are L_WR: mem_en=1, mem_we=1, mem_addr=base+k, mem_wdata=load_data[31-8k -: 8].
  - Cycle 5 is L_DONE: load_done=1.
  - Cycle 6 is IDLE.
- Requests are ignored while busy; a request held through busy is accepted in the first IDLE cycle.
- A misaligned address is silently aligned, with no error output.

Optional Feature:
- Macro IMEM_ARB_RR_EN.
- Defined: round-robin priority. After a fetch is granted, load wins the next simultaneous request; after a load is granted, fetch wins. The pointer resets to fetch-priority.
- Undefined: fixed priority, load always wins; no pointer register is present.

Test Plan:
- Bytes 0..3 = 80 20 00 0A; fetch_req with addr 0 -> fetch_gnt in cycle 0; mem_addr 0,1,2,3 in cycles 1-4; fetch_valid only in cycle 6; fetch_instr=0x8020000A.
- Load addr 0x40, data 0xDEADBEEF -> mem_we=1 in cycles 1-4 with bytes DE,AD,BE,EF at 64..67; load_done in cycle 5. A following fetch of 0x40 returns 0xDEADBEEF.
- fetch_req and load_req in the same IDLE cycle:
  - Fixed priority: load_gnt first; fetch granted in cycle 6; fetch_valid in cycle 12.
  - With IMEM_ARB_RR_EN after a prior load: fetch is granted first.
- Fetch addr 0x10; fetch_flush in cycle 3 -> IDLE in cycle 4; mem_en=0 from cycle 4; no fetch_valid; fetch_instr unchanged. An immediate fetch of 0x14 completes normally.
- MEM_DEPTH=256:
  - Fetch addr 0x102 aligns to 0x100, wraps to bytes 0..3 and returns 0x8020000A.
  - Fetch addr 0xFC reads bytes 252..255.
- rst asserted in cycle 2 of a load -> mem_en and mem_we are 0 next cycle; no load_done; busy=0; remaining bytes are not written.
